// File: rtl/prog_lut_pkg.sv
// Shared constants and types for the programmable truth-table LUT.
package prog_lut_pkg;

    localparam int unsigned RESULT_CNT_W = 16;
    localparam int unsigned DEFAULT_N_IN = 3;

    function automatic int unsigned tt_entries(input int unsigned n);
        return 32'd1 << n;
    endfunction

    typedef logic [(1 << DEFAULT_N_IN)-1:0] tt_default_t;

    // AND function: only the all-ones input combination yields 1.
    localparam tt_default_t TT_AND_DEFAULT = tt_default_t'(1) << ((1 << DEFAULT_N_IN) - 1);

    typedef enum logic {StEmpty, StFull} lut_state_e;

endpackage

// File: rtl/lut_bit_eval.sv
// Evaluates one result bit: selects the truth-table entry addressed by the operand bits.
module lut_bit_eval
    import prog_lut_pkg::*;
#(
    parameter int unsigned N_IN = 3
) (
    input  logic [N_IN-1:0]             sel,
    input  logic [tt_entries(N_IN)-1:0] tt,
    output logic                        result
);

    assign result = tt[sel];

endmodule

// File: rtl/prog_truth_table_lut.sv
// Registered, run-time programmable N_IN-input bitwise truth-table LUT with valid/ready.
// Optional LUT_RESULT_CNT_EN adds a 16-bit wrapping count of output handshakes.
module prog_truth_table_lut
    import prog_lut_pkg::*;
#(
    parameter int unsigned                    N_IN     = 3,
    parameter int unsigned                    WIDTH    = 4,
    parameter logic [tt_entries(N_IN)-1:0]    TT_RESET = {1'b1, {(tt_entries(N_IN)-1){1'b0}}}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_we,
    input  logic [tt_entries(N_IN)-1:0]   cfg_tt,
    output logic [tt_entries(N_IN)-1:0]   tt_o,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_IN*WIDTH-1:0]         in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data
`ifdef LUT_RESULT_CNT_EN
    ,
    output logic [RESULT_CNT_W-1:0]       result_cnt
`endif
);

    localparam int unsigned TT_N = tt_entries(N_IN);

    logic [TT_N-1:0]  tt_q;
    lut_state_e       state_q;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] result;
    logic             accept;

    assign out_valid = (state_q == StFull);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign tt_o      = tt_q;
    assign out_data  = out_data_q;

    // Bit i of every operand forms the table index for result bit i.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [N_IN-1:0] sel;
        for (genvar j = 0; j < N_IN; j++) begin : g_sel
            assign sel[j] = in_data[j*WIDTH + i];
        end
        lut_bit_eval #(
            .N_IN (N_IN)
        ) u_eval (
            .sel    (sel),
            .tt     (tt_q),
            .result (result[i])
        );
    end

    // The result is computed from tt_q, so a same-edge cfg_we still sees the old table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_q       <= TT_RESET;
            state_q    <= StEmpty;
            out_data_q <= '0;
        end else begin
            if (cfg_we) begin
                tt_q <= cfg_tt;
            end
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_q    <= StFull;
                        out_data_q <= result;
                    end
                end
                StFull: begin
                    if (accept) begin
                        out_data_q <= result;
                    end else if (out_ready) begin
                        state_q <= StEmpty;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

`ifdef LUT_RESULT_CNT_EN
    logic [RESULT_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign result_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_prog_truth_table_lut.sv
// Self-checking bench for prog_truth_table_lut: vector table, backpressure, random stream, async reset.
module tb_prog_truth_table_lut;

    localparam int N_IN  = 3;
    localparam int WIDTH = 4;
    localparam int TT_N  = 8;

    logic                  clk;
    logic                  rst_n;
    logic                  cfg_we;
    logic [TT_N-1:0]       cfg_tt;
    logic [TT_N-1:0]       tt_o;
    logic                  in_valid;
    logic                  in_ready;
    logic [N_IN*WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
`ifdef LUT_RESULT_CNT_EN
    logic [15:0]           result_cnt;
`endif

    prog_truth_table_lut #(
        .N_IN  (N_IN),
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_tt     (cfg_tt),
        .tt_o       (tt_o),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef LUT_RESULT_CNT_EN
        ,
        .result_cnt (result_cnt)
`endif
    );

    typedef struct {
        logic       we;
        logic [7:0] tt;
        logic       valid;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] exp;
    } vec_t;

    vec_t       vecs [6];
    logic [3:0] sb [$];
    int         total;
    int         bad;
    int         hs_cnt;
    int         acc_cnt;
    logic [7:0] model_tt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model(input logic [11:0] d, input logic [7:0] t);
        logic [3:0] r;
        logic [2:0] idx;
        for (int i = 0; i < WIDTH; i++) begin
            idx  = {d[8+i], d[4+i], d[i]};
            r[i] = t[idx];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bookkeeping for one cycle; called with inputs set just after a falling edge.
    task automatic step(input logic use_model, input logic [3:0] exp_in);
        logic [3:0] e;
        #1;
        if (out_valid && out_ready) begin
            hs_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e));
            end
        end
        if (in_valid && in_ready) begin
            acc_cnt++;
            sb.push_back(use_model ? model(in_data, model_tt) : exp_in);
        end
        if (cfg_we) model_tt = cfg_tt;
        @(posedge clk);
        @(negedge clk);
        check("tt_o", 32'(tt_o), 32'(model_tt));
    endtask

    initial begin
        int cyc;
        int next_cfg;

        total = 0; bad = 0; hs_cnt = 0; acc_cnt = 0;
        model_tt = 8'h80;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_tt = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        vecs[0] = '{we: 1'b0, tt: 8'h00, valid: 1'b1, a: 4'b1101, b: 4'b1011, c: 4'b1111, exp: 4'b1001};
        vecs[1] = '{we: 1'b1, tt: 8'h96, valid: 1'b0, a: 4'b0000, b: 4'b0000, c: 4'b0000, exp: 4'b0000};
        vecs[2] = '{we: 1'b0, tt: 8'h00, valid: 1'b1, a: 4'b1100, b: 4'b1010, c: 4'b0000, exp: 4'b0110};
        vecs[3] = '{we: 1'b1, tt: 8'h80, valid: 1'b0, a: 4'b0000, b: 4'b0000, c: 4'b0000, exp: 4'b0000};
        vecs[4] = '{we: 1'b1, tt: 8'hFE, valid: 1'b1, a: 4'b0001, b: 4'b0000, c: 4'b0000, exp: 4'b0000};
        vecs[5] = '{we: 1'b0, tt: 8'h00, valid: 1'b1, a: 4'b0001, b: 4'b0000, c: 4'b0000, exp: 4'b0001};

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_tt", 32'(tt_o), 32'h80);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out_data", 32'(out_data), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);

        // Table-driven: AND default, XOR reprogram, same-edge OR config.
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cfg_we   = vecs[k].we;
            cfg_tt   = vecs[k].tt;
            in_valid = vecs[k].valid;
            in_data  = {vecs[k].c, vecs[k].b, vecs[k].a};
            step(1'b0, vecs[k].exp);
        end
        cfg_we = 1'b0; in_valid = 1'b0;
        step(1'b0, 4'h0);
        check("or_table_loaded", 32'(tt_o), 32'hFE);

        // Backpressure: hold a result for 5 cycles while new operands wait.
        in_valid = 1'b1; in_data = {4'b0000, 4'b0100, 4'b0011}; out_ready = 1'b0;
        step(1'b1, 4'h0);
        for (int k = 0; k < 5; k++) begin
            in_data = 12'($urandom);
            #1;
            check("stall_in_ready", 32'(in_ready), 32'h0);
            check("stall_out_valid", 32'(out_valid), 32'h1);
            check("stall_out_data", 32'(out_data), 32'h7);
            step(1'b1, 4'h0);
        end
        in_data = {4'b0000, 4'b0000, 4'b1000}; out_ready = 1'b1;
        step(1'b1, 4'h0);
        check("no_bubble_valid", 32'(out_valid), 32'h1);
        check("no_bubble_data", 32'(out_data), 32'h8);
        in_valid = 1'b0;
        step(1'b1, 4'h0);
        check("drained_valid", 32'(out_valid), 32'h0);

        // Random stream with periodic reprogramming.
        void'($urandom(322));
        acc_cnt  = 0;
        next_cfg = 50;
        cyc      = 0;
        while ((acc_cnt < 1000 || sb.size() > 0) && cyc < 20000) begin
            cfg_we = 1'b0;
            if (acc_cnt >= next_cfg && acc_cnt < 1000) begin
                cfg_we   = 1'b1;
                cfg_tt   = 8'($urandom);
                next_cfg = next_cfg + 50;
            end
            in_valid  = (acc_cnt < 1000) && ($urandom_range(0, 3) != 0);
            in_data   = 12'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step(1'b1, 4'h0);
            cyc++;
        end
        cfg_we = 1'b0; in_valid = 1'b0;
        check("random_accepts", 32'(acc_cnt), 32'd1000);
        check("random_drained", 32'(sb.size()), 32'd0);
`ifdef LUT_RESULT_CNT_EN
        check("result_cnt", 32'(result_cnt), 32'(hs_cnt));
`endif

        // Async reset while a result is held and the table is non-default.
        cfg_we = 1'b1; cfg_tt = 8'h96;
        in_valid = 1'b1; in_data = {4'b0000, 4'b0000, 4'b1111}; out_ready = 1'b0;
        step(1'b1, 4'h0);
        cfg_we = 1'b0; in_valid = 1'b0;
        step(1'b1, 4'h0);
        check("pre_reset_valid", 32'(out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'h0);
        check("async_tt", 32'(tt_o), 32'h80);
        check("async_out_data", 32'(out_data), 32'h0);
        sb.delete();
        model_tt = 8'h80;
        hs_cnt   = 0;
`ifdef LUT_RESULT_CNT_EN
        check("async_result_cnt", 32'(result_cnt), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // AND table back in force after reset.
        in_valid = 1'b1; in_data = {4'b1110, 4'b0111, 4'b1111}; out_ready = 1'b1;
        step(1'b0, 4'b0110);
        in_valid = 1'b0;
        step(1'b0, 4'h0);
        check("final_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
